// File: rtl/prefetch_queue.sv
// prefetch_queue: instruction prefetch buffer in front of an AXI4-Lite read
// port. It keeps at most DEPTH reads either in flight or buffered, tags each
// returned word with its fetch address and hands entries out in fetch order.
// Build option: define PREFETCH_ACCESS_FAULT_EN to turn a non-OKAY rresp into
// an instruction access fault (cause 1, IR forced to zero) carried with the
// entry; without it rresp is ignored and the exception outputs stay zero.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. A producer that has raised valid keeps valid and its payload
// unchanged until that edge. This holds for AR, R and valid_out/ready_in.
module prefetch_queue #(
   parameter int          DEPTH      = 4,
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush_in,
   input  logic [31:0] flush_addr,
   output logic        valid_out,
   input  logic        ready_in,
   output logic [31:0] PC_out,
   output logic [31:0] IR_out,
   output logic        exc_pend_out,
   output logic [31:0] exc_cause_out,
   output logic [31:0] imem_axi_araddr,
   output logic [2:0]  imem_axi_arprot,
   output logic        imem_axi_arvalid,
   input  logic        imem_axi_arready,
   input  logic [31:0] imem_axi_rdata,
   input  logic [1:0]  imem_axi_rresp,
   input  logic        imem_axi_rvalid,
   output logic        imem_axi_rready
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]   pc_mem [DEPTH];
   logic [31:0]   ir_mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count, outstanding, discard;
   logic [CW-1:0] count_n, out_n, disc_n;
   logic [CW:0]   used;
   logic [31:0]   fetch_addr;  // next address to request after the current one
   logic [31:0]   hold_addr;   // address of an AR waiting for arready
   logic [31:0]   resp_pc;     // fetch address of the oldest live outstanding read
   logic          ar_hold;     // an AR was presented and not yet accepted
   logic          ar_stale;    // the held AR predates a flush; its data is dropped
   logic [31:0]   wr_ir;
   logic          ar_hs, ar_new, ar_late;
   logic          r_hs, r_take, r_drop, push, pop;

   // Every buffered entry, live read and doomed read owns one slot; a new
   // read is only requested while a slot is free, so rready can stay high.
   assign used             = (CW+1)'(count) + (CW+1)'(outstanding) + (CW+1)'(discard);
   assign imem_axi_arvalid = ~reset & (ar_hold | (~flush_in & (used < (CW+1)'(DEPTH))));
   assign imem_axi_araddr  = ar_hold ? hold_addr : fetch_addr;
   assign imem_axi_arprot  = 3'b110;
   assign imem_axi_rready  = 1'b1;

   assign ar_hs   = imem_axi_arvalid & imem_axi_arready;
   assign ar_late = ar_hs & ar_hold & ar_stale;
   assign ar_new  = ar_hs & ~(ar_hold & ar_stale);
   assign r_hs    = imem_axi_rvalid;
   assign r_drop  = r_hs & (discard != '0);
   assign r_take  = r_hs & (discard == '0);
   assign push    = r_take & ~flush_in;
   assign pop     = valid_out & ready_in & ~flush_in;

   assign valid_out = (count != '0);
   assign PC_out    = pc_mem[rd_ptr];
   assign IR_out    = ir_mem[rd_ptr];

`ifdef PREFETCH_ACCESS_FAULT_EN
   logic fault;
   logic exc_mem [DEPTH];
   assign fault         = (imem_axi_rresp != 2'b00);
   assign wr_ir         = fault ? 32'h0000_0000 : imem_axi_rdata;
   assign exc_pend_out  = exc_mem[rd_ptr];
   assign exc_cause_out = {31'd0, exc_mem[rd_ptr]};

   // Fault flag storage alongside the PC/IR entries.
   always_ff @(posedge clk) begin
      if (push) exc_mem[wr_ptr] <= fault;
   end
`else
   logic unused_rresp;
   assign unused_rresp  = ^imem_axi_rresp;
   assign wr_ir         = imem_axi_rdata;
   assign exc_pend_out  = 1'b0;
   assign exc_cause_out = 32'd0;
`endif

   // Occupancy bookkeeping; a flush moves every live read (and any read the
   // slave accepts in the flush cycle) into the discard count, minus a
   // response that returns in that same cycle.
   always_comb begin
      count_n = count;
      out_n   = outstanding;
      disc_n  = discard;
      if (flush_in) begin
         count_n = '0;
         out_n   = '0;
         disc_n  = discard + outstanding + CW'(ar_hs) - CW'(r_hs);
      end else begin
         count_n = count + CW'(push) - CW'(pop);
         out_n   = outstanding + CW'(ar_new) - CW'(r_take);
         disc_n  = discard + CW'(ar_late) - CW'(r_drop);
      end
   end

   // Control state: pointers, counters, fetch address and the AR hold latch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         outstanding <= '0;
         discard     <= '0;
         fetch_addr  <= RESET_ADDR;
         hold_addr   <= RESET_ADDR;
         resp_pc     <= RESET_ADDR;
         ar_hold     <= 1'b0;
         ar_stale    <= 1'b0;
      end else begin
         count       <= count_n;
         outstanding <= out_n;
         discard     <= disc_n;
         ar_hold     <= imem_axi_arvalid & ~imem_axi_arready;
         if (imem_axi_arvalid & ~imem_axi_arready & ~ar_hold) hold_addr <= fetch_addr;
         if (flush_in) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fetch_addr <= flush_addr;
            resp_pc    <= flush_addr;
            ar_stale   <= ar_hold & ~imem_axi_arready;
         end else begin
            if (push) begin
               wr_ptr  <= wr_ptr + AW'(1);
               resp_pc <= resp_pc + 32'd4;
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (ar_new) fetch_addr <= fetch_addr + 32'd4;
            if (ar_hs) ar_stale <= 1'b0;
         end
      end
   end

   // Entry storage; responses return in order, so the entry PC is resp_pc.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr] <= resp_pc;
         ir_mem[wr_ptr] <= wr_ir;
      end
   end
endmodule

// File: tb/tb_prefetch_queue.sv
// tb_prefetch_queue: bench for prefetch_queue with an in-order AXI4-Lite
// slave model and a consumer-side model that expects a contiguous PC stream
// restarting at each flush address.
module tb_prefetch_queue;
   localparam int          DEPTH      = 4;
   localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
`ifdef PREFETCH_ACCESS_FAULT_EN
   localparam bit FAULT_EN = 1'b1;
`else
   localparam bit FAULT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        flush_in = 1'b0;
   logic [31:0] flush_addr = 32'h0;
   logic        valid_out;
   logic        ready_in = 1'b0;
   logic [31:0] PC_out, IR_out, exc_cause_out;
   logic        exc_pend_out;
   logic [31:0] araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready = 1'b0;
   logic [31:0] rdata = 32'h0;
   logic [1:0]  rresp = 2'b00;
   logic        rvalid = 1'b0;
   logic        rready;

   prefetch_queue #(.DEPTH(DEPTH), .RESET_ADDR(RESET_ADDR)) dut (
      .clk(clk), .reset(reset), .flush_in(flush_in), .flush_addr(flush_addr),
      .valid_out(valid_out), .ready_in(ready_in), .PC_out(PC_out), .IR_out(IR_out),
      .exc_pend_out(exc_pend_out), .exc_cause_out(exc_cause_out),
      .imem_axi_araddr(araddr), .imem_axi_arprot(arprot), .imem_axi_arvalid(arvalid),
      .imem_axi_arready(arready), .imem_axi_rdata(rdata), .imem_axi_rresp(rresp),
      .imem_axi_rvalid(rvalid), .imem_axi_rready(rready)
   );

   // clock
   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          pops = 0;
   logic [31:0] first_pc;
   logic [31:0] slave_q[$];   // addresses accepted by the slave, oldest first
   logic [31:0] ar_log[$];    // accepted AR addresses, cleared by tests
   logic [31:0] exp_q[$];     // expected PC of the next consumed entry (head)
   logic        prev_pend = 1'b0;
   logic [31:0] prev_addr = 32'h0;
   logic        k_arready = 1'b0, k_rsp = 1'b0, k_ready_in = 1'b0, k_flush = 1'b0;
   logic [31:0] k_flush_addr = 32'h0;
   logic        s_arvalid, s_valid;
   logic [31:0] s_araddr, s_pc;

   typedef struct {
      logic        ready_in;
      logic        exp_arvalid;
      logic [31:0] exp_araddr;
      logic        exp_valid;
      logic [31:0] exp_pc;
   } vec_t;
   vec_t tbl[9];

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return a ^ 32'hC0DE_1234;
   endfunction

   function automatic logic fault_at(input logic [31:0] a);
      return a[5:2] == 4'd2;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive at the falling edge, sample 1ns later, update models.
   task automatic cycle();
      logic [31:0] e_pc;
      logic        e_exc;
      arready    = k_arready;
      ready_in   = k_ready_in;
      flush_in   = k_flush;
      flush_addr = k_flush_addr;
      if (k_rsp && slave_q.size() > 0) begin
         rvalid = 1'b1;
         rdata  = word_of(slave_q[0]);
         rresp  = fault_at(slave_q[0]) ? 2'b10 : 2'b00;
      end else begin
         rvalid = 1'b0;
         rdata  = $urandom;
         rresp  = 2'b00;
      end
      #1;
      s_arvalid = arvalid;
      s_araddr  = araddr;
      s_valid   = valid_out;
      s_pc      = PC_out;
      chk("rready_high", 32'(rready), 32'd1);
      if (arvalid) chk("arprot", 32'(arprot), 32'd6);
      if (prev_pend) begin
         chk("ar_held_valid", 32'(arvalid), 32'd1);
         chk("ar_held_addr", araddr, prev_addr);
      end
      prev_pend = arvalid & ~arready;
      prev_addr = araddr;
      if (rvalid) void'(slave_q.pop_front());
      if (arvalid && arready) begin
         slave_q.push_back(araddr);
         ar_log.push_back(araddr);
      end
      chk("inflight_le_depth", 32'(slave_q.size() <= DEPTH), 32'd1);
      if (valid_out && ready_in && !flush_in) begin
         e_pc  = exp_q.pop_front();
         e_exc = FAULT_EN && fault_at(e_pc);
         chk("pop_pc", PC_out, e_pc);
         chk("pop_ir", IR_out, e_exc ? 32'h0 : word_of(e_pc));
         chk("pop_exc", 32'(exc_pend_out), 32'(e_exc));
         chk("pop_cause", exc_cause_out, e_exc ? 32'd1 : 32'd0);
         exp_q.push_back(e_pc + 32'd4);
         if (pops == 0) first_pc = PC_out;
         pops++;
      end
      if (flush_in) begin
         exp_q.delete();
         exp_q.push_back(flush_addr);
      end
      @(negedge clk);
   endtask

   // Reset for n cycles (asynchronously, from a falling edge) with checks.
   task automatic do_reset(input int n);
      reset    = 1'b1;
      arready  = 1'b0;
      rvalid   = 1'b0;
      ready_in = 1'b0;
      flush_in = 1'b0;
      slave_q.delete();
      exp_q.delete();
      exp_q.push_back(RESET_ADDR);
      prev_pend = 1'b0;
      k_flush   = 1'b0;
      for (int i = 0; i < n; i++) begin
         #1;
         chk("rst_valid_out", 32'(valid_out), 32'd0);
         chk("rst_arvalid", 32'(arvalid), 32'd0);
         chk("rst_araddr", araddr, RESET_ADDR);
         @(negedge clk);
      end
      reset = 1'b0;
   endtask

   task automatic run_until_pop(input string name, input int budget);
      pops = 0;
      for (int i = 0; i < budget && pops == 0; i++) cycle();
      chk(name, 32'(pops > 0), 32'd1);
   endtask

   initial begin
      // ready_in, exp_arvalid, exp_araddr, exp_valid, exp_pc
      tbl[0] = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h0};
      tbl[1] = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h0};
      tbl[2] = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h0};
      tbl[3] = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h0};
      tbl[4] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0};
      tbl[5] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h0};
      tbl[6] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h4};
      tbl[7] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h4};
      tbl[8] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h4};

      @(negedge clk);
      do_reset(3);

      // Fill with the consumer stalled, then release one entry.
      k_arready = 1'b1; k_rsp = 1'b1;
      foreach (tbl[i]) begin
         k_ready_in = tbl[i].ready_in;
         cycle();
         chk($sformatf("tbl%0d_arvalid", i), 32'(s_arvalid), 32'(tbl[i].exp_arvalid));
         if (tbl[i].exp_arvalid) chk($sformatf("tbl%0d_araddr", i), s_araddr, tbl[i].exp_araddr);
         chk($sformatf("tbl%0d_valid", i), 32'(s_valid), 32'(tbl[i].exp_valid));
         if (tbl[i].exp_valid) chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].exp_pc);
      end

      // Streaming with no stalls: one entry per cycle once filled.
      do_reset(2);
      k_arready = 1'b1; k_rsp = 1'b1; k_ready_in = 1'b1;
      pops = 0;
      repeat (20) cycle();
      chk("stream_pops", 32'(pops), 32'd18);

      // Flush with three reads outstanding.
      do_reset(2);
      k_arready = 1'b1; k_rsp = 1'b0; k_ready_in = 1'b0;
      ar_log.delete();
      repeat (3) cycle();
      chk("pre_flush_ars", 32'(ar_log.size()), 32'd3);
      k_flush = 1'b1; k_flush_addr = 32'h100;
      ar_log.delete();
      cycle();
      k_flush = 1'b0; k_rsp = 1'b1; k_ready_in = 1'b1;
      run_until_pop("flush3_pop_seen", 40);
      chk("flush3_first_pc", first_pc, 32'h100);
      chk("flush3_first_ar", ar_log.size() > 0 ? ar_log[0] : 32'hFFFF_FFFF, 32'h100);

      // Flush while an AR is held by arready=0.
      do_reset(2);
      k_arready = 1'b0; k_rsp = 1'b1; k_ready_in = 1'b1;
      repeat (2) cycle();
      k_flush = 1'b1; k_flush_addr = 32'h100;
      cycle();
      chk("hold_flush_arvalid", 32'(s_arvalid), 32'd1);
      chk("hold_flush_araddr", s_araddr, 32'h0);
      k_flush = 1'b0;
      cycle();
      chk("hold_after_araddr", s_araddr, 32'h0);
      ar_log.delete();
      k_arready = 1'b1;
      run_until_pop("hold_pop_seen", 40);
      chk("hold_first_pc", first_pc, 32'h100);
      chk("hold_ar_count", 32'(ar_log.size() >= 2), 32'd1);
      if (ar_log.size() >= 2) begin
         chk("hold_ar0", ar_log[0], 32'h0);
         chk("hold_ar1", ar_log[1], 32'h100);
      end

      // Back-to-back flushes: the last address wins.
      do_reset(2);
      k_arready = 1'b1; k_rsp = 1'b0; k_ready_in = 1'b0;
      repeat (2) cycle();
      k_flush = 1'b1; k_flush_addr = 32'h200;
      cycle();
      k_flush_addr = 32'h300;
      cycle();
      k_flush = 1'b0; k_rsp = 1'b1; k_ready_in = 1'b1;
      run_until_pop("b2b_pop_seen", 40);
      chk("b2b_first_pc", first_pc, 32'h300);

      // Reset in the middle of traffic, then restart from RESET_ADDR.
      do_reset(2);
      k_arready = 1'b1; k_rsp = 1'b1; k_ready_in = 1'b1;
      repeat (5) cycle();
      do_reset(2);
      run_until_pop("rst_mid_pop_seen", 20);
      chk("rst_mid_first_pc", first_pc, RESET_ADDR);

      // Random stalls and flushes against the consumer model.
      do_reset(2);
      pops = 0;
      for (int i = 0; i < 10000; i++) begin
         k_arready  = ($urandom_range(0, 3) != 0);
         k_rsp      = ($urandom_range(0, 3) != 0);
         k_ready_in = ($urandom_range(0, 2) != 0);
         k_flush    = ($urandom_range(0, 59) == 0);
         k_flush_addr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
         cycle();
      end
      chk("rand_progress", 32'(pops > 1000), 32'd1);
      k_flush = 1'b0; k_arready = 1'b1; k_rsp = 1'b1; k_ready_in = 1'b1;
      pops = 0;
      repeat (40) cycle();
      chk("drain_progress", 32'(pops >= 30), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
